// File: rtl/me_pad_if_pkg.sv
// Shared constants, serializer state encoding and packet-geometry helpers for the pad interface.
// Pure declarations: no latency or backpressure of its own.
package me_pad_if_pkg;

  localparam int IN_W_DEF       = 32;
  localparam int WORD_WIDTH_DEF = 8;
  localparam int LOAD_WORDS_DEF = 64;
  localparam int MV_W_DEF       = 5;
  localparam int SAD_W_DEF      = 16;
  localparam int N_LANES_DEF    = 1;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_SHIFT
  } ser_state_t;

  function automatic int pkt_width(input int mv_w, input int sad_w);
    return 2 * mv_w + sad_w;
  endfunction

  // Chunks needed to carry pkt_w bits over the given number of lanes (rounded up).
  function automatic int num_chunks(input int pkt_w, input int lanes);
    return (pkt_w + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/me_res_ser.sv
// Result serializer: frames {mvx, mvy, sad} as one all-ones start cycle followed by NB MSB-first chunks.
// Output appears the cycle after capture; res_ready is high only while idle, so results wait upstream.
module me_res_ser
  import me_pad_if_pkg::*;
#(
  parameter int MV_W    = MV_W_DEF,
  parameter int SAD_W   = SAD_W_DEF,
  parameter int N_LANES = N_LANES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [MV_W-1:0]    res_mvx,
  input  logic [MV_W-1:0]    res_mvy,
  input  logic [SAD_W-1:0]   res_sad,
  input  logic               res_valid,
  output logic               res_ready,
  output logic [N_LANES-1:0] serial_out
);

  localparam int PKT_W = pkt_width(MV_W, SAD_W);
  localparam int NB    = num_chunks(PKT_W, N_LANES);
  localparam int SR_W  = NB * N_LANES;
  localparam int CNT_W = $clog2(NB + 1);

  ser_state_t         state, state_nxt;
  logic [SR_W-1:0]    shift_reg;
  logic [CNT_W-1:0]   chunk_cnt;
  logic [PKT_W-1:0]   pkt;
  logic               capture;
  logic               last_chunk;

  assign pkt        = {res_mvx, res_mvy, res_sad};
  assign last_chunk = (chunk_cnt == CNT_W'(NB - 1));

  always_comb begin
    state_nxt  = state;
    res_ready  = 1'b0;
    serial_out = '0;
    capture    = 1'b0;
    case (state)
      SER_IDLE: begin
        res_ready = 1'b1;
        if (res_valid) begin
          capture   = 1'b1;
          state_nxt = SER_START;
        end
      end
      SER_START: begin
        serial_out = '1;
        state_nxt  = SER_SHIFT;
      end
      SER_SHIFT: begin
        serial_out = shift_reg[SR_W-1 -: N_LANES];
        if (last_chunk) state_nxt = SER_IDLE;
      end
      default: state_nxt = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SER_IDLE;
      shift_reg <= '0;
      chunk_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        // Left-justify so any padding lands in the final chunk's low bits.
        shift_reg <= SR_W'(pkt) << (SR_W - PKT_W);
        chunk_cnt <= '0;
      end else if (state == SER_SHIFT) begin
        shift_reg <= shift_reg << N_LANES;
        chunk_cnt <= last_chunk ? '0 : chunk_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/me_pad_if.sv
// Pad interface: registers LOAD_WORDS pixel words per init-started session and serializes core results.
// Pixel path latency 1 with no backpressure; result path holds res_ready low while a frame is on the lanes.
module me_pad_if
  import me_pad_if_pkg::*;
#(
  parameter int IN_W       = IN_W_DEF,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int LOAD_WORDS = LOAD_WORDS_DEF,
  parameter int MV_W       = MV_W_DEF,
  parameter int SAD_W      = SAD_W_DEF,
  parameter int N_LANES    = N_LANES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init,
  input  logic [IN_W-1:0]    input_raw,
  output logic [IN_W-1:0]    pix_data,
  output logic               pix_valid,
  output logic               load_done,
  input  logic [MV_W-1:0]    res_mvx,
  input  logic [MV_W-1:0]    res_mvy,
  input  logic [SAD_W-1:0]   res_sad,
  input  logic               res_valid,
  output logic               res_ready,
  output logic [N_LANES-1:0] serial_out
);

  localparam int CNT_W = $clog2(LOAD_WORDS + 1);

  if (IN_W % WORD_WIDTH != 0) begin : g_bad_width
    $error("IN_W must be a multiple of WORD_WIDTH");
  end

  logic             active;
  logic [CNT_W-1:0] word_cnt;
  logic             last_word;

  assign last_word = (word_cnt == CNT_W'(LOAD_WORDS - 1));

  // init wins over an in-flight session: the aborted session never raises load_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= 1'b0;
      word_cnt  <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      load_done <= 1'b0;
    end else if (init) begin
      active    <= 1'b1;
      word_cnt  <= '0;
      pix_valid <= 1'b0;
      load_done <= 1'b0;
    end else if (active) begin
      pix_data  <= input_raw;
      pix_valid <= 1'b1;
      load_done <= last_word;
      if (last_word) begin
        active   <= 1'b0;
        word_cnt <= '0;
      end else begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end else begin
      pix_valid <= 1'b0;
      load_done <= 1'b0;
    end
  end

  me_res_ser #(
    .MV_W    (MV_W),
    .SAD_W   (SAD_W),
    .N_LANES (N_LANES)
  ) u_res_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .res_mvx    (res_mvx),
    .res_mvy    (res_mvy),
    .res_sad    (res_sad),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .serial_out (serial_out)
  );

endmodule

// File: tb/tb_me_pad_if.sv
// Directed bench for me_pad_if: one instance with a single serial lane, one with four lanes.
module tb_me_pad_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init;
  logic [31:0] input_raw;
  logic [4:0]  res_mvx, res_mvy;
  logic [15:0] res_sad;
  logic        res_valid;

  logic [31:0] pix_data1, pix_data4;
  logic        pix_valid1, pix_valid4, load_done1, load_done4;
  logic        res_ready1, res_ready4;
  logic [0:0]  serial_out1;
  logic [3:0]  serial_out4;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  mvx;
    logic [4:0]  mvy;
    logic [15:0] sad;
    logic [25:0] exp1;  // 1-lane bit stream, MSB first
    logic [27:0] exp4;  // 4-lane chunks, two pad zeros at the end
  } ser_vec_t;

  ser_vec_t vt [4];

  always #5 clk = ~clk;

  me_pad_if #(.N_LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .init(init), .input_raw(input_raw),
    .pix_data(pix_data1), .pix_valid(pix_valid1), .load_done(load_done1),
    .res_mvx(res_mvx), .res_mvy(res_mvy), .res_sad(res_sad),
    .res_valid(res_valid), .res_ready(res_ready1), .serial_out(serial_out1)
  );

  me_pad_if #(.N_LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .init(init), .input_raw(input_raw),
    .pix_data(pix_data4), .pix_valid(pix_valid4), .load_done(load_done4),
    .res_mvx(res_mvx), .res_mvy(res_mvy), .res_sad(res_sad),
    .res_valid(res_valid), .res_ready(res_ready4), .serial_out(serial_out4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_frame(input ser_vec_t v);
    @(negedge clk);
    chk("idle_ser1", 32'(serial_out1), 32'h0);
    chk("idle_rdy", 32'({res_ready4, res_ready1}), 32'h3);
    res_mvx   = v.mvx;
    res_mvy   = v.mvy;
    res_sad   = v.sad;
    res_valid = 1'b1;
    @(posedge clk);
    #1 res_valid = 1'b0;
    for (int c = 0; c <= 27; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("start1", 32'(serial_out1), 32'h1);
        chk("start4", 32'(serial_out4), 32'hF);
        chk("start_rdy", 32'({res_ready4, res_ready1}), 32'h0);
      end else if (c <= 26) begin
        chk("bit1", 32'(serial_out1), 32'(v.exp1[26-c]));
        chk("rdy1_busy", 32'(res_ready1), 32'h0);
        if (c <= 7) begin
          chk("chunk4", 32'(serial_out4), 32'(v.exp4[27-4*(c-1) -: 4]));
          chk("rdy4_busy", 32'(res_ready4), 32'h0);
        end else begin
          chk("post4_ser", 32'(serial_out4), 32'h0);
          chk("post4_rdy", 32'(res_ready4), 32'h1);
        end
      end else begin
        chk("end1_ser", 32'(serial_out1), 32'h0);
        chk("end1_rdy", 32'(res_ready1), 32'h1);
      end
    end
  endtask

  initial begin
    int ld_cnt;
    int hs4;
    int f;
    int p;

    vt[0] = '{mvx: 5'h1F, mvy: 5'h01, sad: 16'h00A5, exp1: 26'h3E100A5, exp4: 28'hF840294};
    vt[1] = '{mvx: 5'h0A, mvy: 5'h15, sad: 16'hFFFF, exp1: 26'h155FFFF, exp4: 28'h557FFFC};
    vt[2] = '{mvx: 5'h00, mvy: 5'h00, sad: 16'h0000, exp1: 26'h0000000, exp4: 28'h0000000};
    vt[3] = '{mvx: 5'h10, mvy: 5'h1F, sad: 16'h8001, exp1: 26'h21F8001, exp4: 28'h87E0004};

    rst_n = 1'b0; init = 1'b0; input_raw = '0;
    res_mvx = '0; res_mvy = '0; res_sad = '0; res_valid = 1'b0;

    // Reset state
    #12;
    chk("rst_pix_data", pix_data1, 32'h0);
    chk("rst_pix_valid", 32'({pix_valid4, pix_valid1}), 32'h0);
    chk("rst_load_done", 32'({load_done4, load_done1}), 32'h0);
    chk("rst_serial", 32'({serial_out4, serial_out1}), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rdy", 32'({res_ready4, res_ready1}), 32'h3);

    // Full load session: words 0..63
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    input_raw = 32'd0;
    chk("init_cycle_valid", 32'(pix_valid1), 32'h0);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("load_data", pix_data1, 32'(i));
      chk("load_valid", 32'(pix_valid1), 32'h1);
      chk("load_done", 32'(load_done1), 32'(i == 63));
      input_raw = 32'(i + 1);
    end
    @(negedge clk);
    chk("after_valid", 32'(pix_valid1), 32'h0);
    chk("after_done", 32'(load_done1), 32'h0);
    chk("after_hold", pix_data1, 32'd63);

    // Restart mid-session at word 20
    ld_cnt = 0;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    input_raw = 32'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("pre_restart_data", pix_data1, 32'(i));
      if (load_done1) ld_cnt++;
      input_raw = 32'(i + 1);
    end
    init = 1'b1;
    @(negedge clk);
    chk("restart_gap_valid", 32'(pix_valid1), 32'h0);
    if (load_done1) ld_cnt++;
    init = 1'b0;
    input_raw = 32'd100;
    for (int j = 0; j < 64; j++) begin
      @(negedge clk);
      chk("restart_data", pix_data1, 32'(100 + j));
      chk("restart_valid", 32'(pix_valid1), 32'h1);
      if (load_done1) ld_cnt++;
      input_raw = 32'(101 + j);
    end
    @(negedge clk);
    if (load_done1) ld_cnt++;
    chk("restart_end_valid", 32'(pix_valid1), 32'h0);
    chk("restart_one_done", 32'(ld_cnt), 32'd1);

    // Serializer vectors
    for (int k = 0; k < 4; k++) run_frame(vt[k]);

    // res_valid held high: dut4 frames back to back, new result presented at each handshake
    @(negedge clk);
    res_mvx = vt[0].mvx; res_mvy = vt[0].mvy; res_sad = vt[0].sad;
    res_valid = 1'b1;
    hs4 = (res_ready4 && res_valid) ? 1 : 0;
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      f = c / 9;
      p = c % 9;
      if (p == 0) begin
        chk("b2b_start", 32'(serial_out4), 32'hF);
        chk("b2b_rdy_lo", 32'(res_ready4), 32'h0);
      end else if (p <= 7) begin
        chk("b2b_chunk", 32'(serial_out4), 32'(vt[f].exp4[27-4*(p-1) -: 4]));
      end else begin
        chk("b2b_gap", 32'(serial_out4), 32'h0);
        chk("b2b_rdy_hi", 32'(res_ready4), 32'h1);
        if (c < 26) begin
          if (res_ready4 && res_valid) hs4++;
          res_mvx = vt[f+1].mvx; res_mvy = vt[f+1].mvy; res_sad = vt[f+1].sad;
        end else begin
          res_valid = 1'b0;
        end
      end
    end
    chk("b2b_handshakes", 32'(hs4), 32'd3);
    @(negedge clk);
    chk("b2b_idle4", 32'({res_ready4, serial_out4}), 32'h10);
    chk("b2b_idle1", 32'({res_ready1, serial_out1}), 32'h2);

    // Reset mid-load and mid-frame
    init = 1'b1;
    res_mvx = vt[1].mvx; res_mvy = vt[1].mvy; res_sad = vt[1].sad;
    res_valid = 1'b1;
    @(negedge clk);
    init = 1'b0;
    res_valid = 1'b0;
    input_raw = 32'hAA;
    repeat (4) @(negedge clk) input_raw = input_raw + 32'd1;
    chk("pre_rst_ser4", 32'(serial_out4 != 4'h0), 32'h1);
    chk("pre_rst_valid", 32'(pix_valid1), 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pix", pix_data1, 32'h0);
    chk("mid_rst_valid", 32'({pix_valid4, pix_valid1}), 32'h0);
    chk("mid_rst_done", 32'({load_done4, load_done1}), 32'h0);
    chk("mid_rst_ser", 32'({serial_out4, serial_out1}), 32'h0);
    chk("mid_rst_pix4", pix_data4, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    ld_cnt = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(pix_valid1), 32'h0);
      chk("post_rst_ser", 32'({serial_out4, serial_out1}), 32'h0);
      chk("post_rst_rdy", 32'({res_ready4, res_ready1}), 32'h3);
      if (load_done1 || load_done4) ld_cnt++;
      input_raw = input_raw + 32'd1;
    end
    chk("post_rst_no_done", 32'(ld_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/me_pad_if.md
ME_PAD_IF -- requirements
Module: me_pad_if

Interface
REQ-001 SHALL have parameter IN_W, default 32, width of the parallel pixel input bus.
REQ-002 SHALL have parameter WORD_WIDTH, default 8, pixel width; IN_W SHALL be a multiple of WORD_WIDTH.
REQ-003 SHALL have parameter LOAD_WORDS, default 64, input words per load session (16x16 block at 4 pixels/word).
REQ-004 SHALL have parameter MV_W, default 5, signed motion-vector component width.
REQ-005 SHALL have parameter SAD_W, default 16, SAD result width.
REQ-006 SHALL have parameter N_LANES, default 1, number of serial result output lanes.
REQ-007 SHALL have port clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have port init  input  1  synchronous start-of-load pulse.
REQ-010 SHALL have port input_raw  input  IN_W  parallel pixel word from pads.
REQ-011 SHALL have port pix_data  output  IN_W  registered pixel word to core.
REQ-012 SHALL have port pix_valid  output  1  pix_data holds a session word this cycle.
REQ-013 SHALL have port load_done  output  1  one-cycle pulse with final word of a session.
REQ-014 SHALL have ports res_mvx, res_mvy  input  MV_W each, and res_sad  input  SAD_W: result from core.
REQ-015 SHALL have ports res_valid  input  1  and res_ready  output  1: result handshake.
REQ-016 SHALL have port serial_out  output  N_LANES  serial result lanes to pads.

Function
REQ-017 Load: init high at edge t starts a session; input_raw is sampled on edges t+1 .. t+LOAD_WORDS, each appearing on pix_data with pix_valid high after the sampling edge (latency 1).
REQ-018 Word counter SHALL count 0..LOAD_WORDS-1; load_done SHALL be high with the word at count LOAD_WORDS-1; then pix_valid drops and counter returns to 0.
REQ-019 init asserted mid-session SHALL restart: counter to 0, no load_done for the aborted session, sampling continues from next edge.
REQ-020 pix_data SHALL hold its last value when pix_valid is low; no backpressure exists on the pixel path.
REQ-021 Packet PKT = {res_mvx, res_mvy, res_sad}, PKT_W = 2*MV_W+SAD_W (26 default), zero-padded at LSB end to NB = ceil(PKT_W/N_LANES) chunks.
REQ-022 Serializer FSM states IDLE, START, SHIFT; res_ready SHALL be high only in IDLE.
REQ-023 IDLE: serial_out all 0; res_valid&res_ready captures PKT into a shift register and moves to START.
REQ-024 START: one cycle, serial_out all 1 (start marker); then SHIFT.
REQ-025 SHIFT: NB cycles, each drives the next N_LANES packet bits MSB first, lane N_LANES-1 carrying the more significant bit; after NB-th cycle returns to IDLE.
REQ-026 Frame length SHALL be 1+NB cycles; back-to-back results SHALL have at least one IDLE (0) cycle between frames.
REQ-027 Load and serializer paths SHALL operate independently and concurrently; init SHALL NOT affect the serializer.

Reset
REQ-028 rst_n low SHALL asynchronously force: pix_data 0, pix_valid 0, load_done 0, counter 0, FSM IDLE, res_ready 1 after release, serial_out 0.
REQ-029 Reset mid-session or mid-frame SHALL abandon it; no partial output SHALL resume after release.

Structure
REQ-030 Shared package SHALL hold PKT_W/NB derivation, FSM state enum and default parameter constants.
REQ-031 Serializer SHALL be one sub-module me_res_ser; load logic SHALL stay in me_pad_if.

Verification
REQ-032 Defaults, init then input_raw = 0..63 -> pix_data 0..63 on consecutive cycles, load_done with 63, pix_valid low after.
REQ-033 init again at word 20 -> counter restarts, next 64 words delivered, exactly one load_done.
REQ-034 N_LANES=1, mvx=5'h1F, mvy=5'h01, sad=16'h00A5 -> serial_out 0..,1 then 11111 00001 0000000010100101, then 0; frame 27 cycles.
REQ-035 N_LANES=4, same result -> start cycle 4'hF, then 7 chunks ending with 2 pad zeros; res_ready low for 8 cycles.
REQ-036 res_valid held high continuously -> frames separated by exactly one idle 0 cycle; each result captured once.
REQ-037 rst_n pulsed low mid-frame and mid-load -> all outputs 0 immediately, res_ready 1 after release, no stray load_done.
